inst_decode_reg: RTL and testbench
==================================

# inst_decode_reg

Instruction register and decode stage of the multicycle MIPS core. Captures the fetched word from memory on `ir_write` and drives the one-hot instruction-class flags consumed by the multicycle control state machine. Drives the register-file index fields, the sign-extended immediate and the jump target to the datapath. Keeps sticky illegal-instruction status and retired/illegal instruction counters for debug.

## Interface
- `NOP_WORD`, 32'h0000_0000: encoding treated as a legal no-op (no flag asserted).
- `ILL_CNT_W`, 16: width of the saturating illegal-instruction counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low. The top level derives the active-high controller reset from the same net.
- `mem_rdata` in 32: memory read data, valid when `ir_write` is high.
- `ir_write` in 1: capture `mem_rdata` into IR at this edge; driven by the controller's IRWrite.
- `clr_cnt` in 1: synchronous clear of counters and sticky status.
- `ir` out 32: current instruction register.
- `rs_idx`, `rt_idx`, `rd_idx` out 5 each: `ir[25:21]`, `ir[20:16]`, `ir[15:11]`.
- `funct` out 6: `ir[5:0]`.
- `imm_sext` out 32: `{{16{ir[15]}}, ir[15:0]}`.
- `jtarget` out 26: `ir[25:0]`.
- `RT`, `addi`, `andi`, `lw`, `sw`, `j`, `jal`, `jr`, `beq`, `bne` out 1 each: class flags, at most one high.
- `illegal` out 1: current IR is neither a supported encoding nor `NOP_WORD`.
- `trap` out 1: one-cycle pulse, first cycle an illegal IR is visible.
- `illegal_seen` out 1: sticky illegal indication.
- `inst_cnt` out 32: instructions captured, wraps.
- `illegal_cnt` out `ILL_CNT_W`: illegal captures, saturates at all-ones.

## Operation
- IR capture: on a rising edge with `rst`=1 and `ir_write`=1, `ir <= mem_rdata`. Otherwise IR holds.
- Flags and fields are combinational from the registered IR only, never from `mem_rdata`.
- Opcode decode:
  - 001000 → addi
  - 001100 → andi
  - 100011 → lw
  - 101011 → sw
  - 000010 → j
  - 000011 → jal
  - 000100 → beq
  - 000101 → bne
- Opcode 000000 (R-type) decode by funct:
  - 001000 → jr only; `RT` stays low.
  - 100000, 100010, 100100, 100101, 101010 → `RT`.
- `ir == NOP_WORD` → all flags low, `illegal`=0.
- Any other encoding → all flags low, `illegal`=1. The controller then returns from ID to IF.
- Counters and status update on each capture edge, from the decode of `mem_rdata`:
  - `inst_cnt` += 1.
  - If that word decodes illegal: `illegal_cnt` += 1 (saturating) and `illegal_seen` <= 1.
- `trap`: registered pulse, high in the cycle after an illegal capture only. Holding an illegal IR does not re-pulse.
- `clr_cnt`=1 zeroes `inst_cnt`, `illegal_cnt` and `illegal_seen` and takes priority. A capture in the same cycle still loads IR and can still raise `trap`, but is not counted and does not set sticky status.

## Timing
- Reset (edge with `rst`=0):
  - `ir`=0, so decode gives NOP: all flags low, `illegal`=0, `imm_sext`=0, `jtarget`=0.
  - `trap`=0, `illegal_seen`=0, `inst_cnt`=0, `illegal_cnt`=0.
  - Reset overrides `ir_write` and `clr_cnt`.
- Latency: word captured at the end of the controller's IF cycle; flags are valid throughout the following ID cycle and remain stable until the next `ir_write`.
- `trap` aligns with that ID cycle.
- Boundaries:
  - `inst_cnt` wraps FFFF_FFFF → 0.
  - `illegal_cnt` holds at all-ones.
  - Back-to-back `ir_write` each count.
  - Reset mid-instruction discards IR.

## Structure
- Shared package `mips_isa_pkg` holds:
  - opcode constants (`OP_RTYPE`, `OP_ADDI`, `OP_ANDI`, `OP_LW`, `OP_SW`, `OP_J`, `OP_JAL`, `OP_BEQ`, `OP_BNE`);
  - funct constants (`FN_ADD`, `FN_SUB`, `FN_AND`, `FN_OR`, `FN_SLT`, `FN_JR`).
- One combinational sub-module, `opcode_decode` (32-bit word in, ten flags plus `illegal` out), is instantiated twice:
  - on `ir`, for the outputs;
  - on `mem_rdata`, for capture-time counting.

## Test plan
- Reset, then idle 3 cycles → `ir`=0, all flags 0, `inst_cnt`=0, `trap`=0.
- Capture 0x8C22_0004 (lw) → next cycle `lw`=1, `rs_idx`=1, `rt_idx`=2, `imm_sext`=4, `inst_cnt`=1.
- Capture 0x2001_FFFF (addi), then 0x03E0_0008 (jr) → `imm_sext`=FFFF_FFFF with `addi`=1; then `jr`=1 with `RT`=0.
- Capture 0xFC00_0000 → `illegal`=1, `trap` high exactly one cycle, `illegal_seen`=1, `illegal_cnt`=1. Hold 5 cycles → no further trap.
- `clr_cnt` coincident with an illegal capture → IR loaded, `trap`=1, both counters 0, `illegal_seen`=0.
- Force `illegal_cnt` to FFFF, capture another illegal word → stays FFFF while `inst_cnt` increments. Assert `rst`=0 mid-sequence → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants and the decoded instruction-class flag bundle
// used by the decode stage and the multicycle controller.
package mips_isa_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_JR    = 6'b001000;

   typedef struct packed {
      logic rt;
      logic addi;
      logic andi;
      logic lw;
      logic sw;
      logic j;
      logic jal;
      logic jr;
      logic beq;
      logic bne;
   } dec_flags_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational instruction-class decoder: one-hot class flags plus an
// illegal indication for any word that is neither supported nor the no-op.
module opcode_decode
   import mips_isa_pkg::*;
#(
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic [31:0] word,
   output dec_flags_t  flags,
   output logic        illegal
);

   // Opcode/funct decode; the no-op word is forced flag-free even if it aliases a class.
   always_comb begin
      flags   = '0;
      illegal = 1'b0;
      case (word[31:26])
         OP_RTYPE: begin
            case (word[5:0])
               FN_JR:                                  flags.jr = 1'b1;
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:  flags.rt = 1'b1;
               default:                                flags    = '0;
            endcase
         end
         OP_ADDI: flags.addi = 1'b1;
         OP_ANDI: flags.andi = 1'b1;
         OP_LW:   flags.lw   = 1'b1;
         OP_SW:   flags.sw   = 1'b1;
         OP_J:    flags.j    = 1'b1;
         OP_JAL:  flags.jal  = 1'b1;
         OP_BEQ:  flags.beq  = 1'b1;
         OP_BNE:  flags.bne  = 1'b1;
         default: flags      = '0;
      endcase
      if (word == NOP_WORD) begin
         flags   = '0;
         illegal = 1'b0;
      end else begin
         illegal = ~(|flags);
      end
   end

endmodule

// File: rtl/inst_decode_reg.sv
// Instruction register and decode stage of the multicycle MIPS core, with
// sticky illegal-instruction status and debug instruction counters.
module inst_decode_reg
   import mips_isa_pkg::*;
#(
   parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
   parameter int          ILL_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          mem_rdata,
   input  logic                 ir_write,
   input  logic                 clr_cnt,
   output logic [31:0]          ir,
   output logic [4:0]           rs_idx,
   output logic [4:0]           rt_idx,
   output logic [4:0]           rd_idx,
   output logic [5:0]           funct,
   output logic [31:0]          imm_sext,
   output logic [25:0]          jtarget,
   output logic                 RT,
   output logic                 addi,
   output logic                 andi,
   output logic                 lw,
   output logic                 sw,
   output logic                 j,
   output logic                 jal,
   output logic                 jr,
   output logic                 beq,
   output logic                 bne,
   output logic                 illegal,
   output logic                 trap,
   output logic                 illegal_seen,
   output logic [31:0]          inst_cnt,
   output logic [ILL_CNT_W-1:0] illegal_cnt
);

   localparam logic [ILL_CNT_W-1:0] ILL_ONE = {{(ILL_CNT_W-1){1'b0}}, 1'b1};

   logic [31:0]          ir_q, ir_d;
   logic                 trap_q, trap_d;
   logic                 seen_q, seen_d;
   logic [31:0]          inst_cnt_q, inst_cnt_d;
   logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

   dec_flags_t ir_flags_s, mem_flags_s;
   logic       ir_illegal_s, mem_illegal_s, cap_illegal_s;

   opcode_decode #(.NOP_WORD(NOP_WORD)) u_dec_ir (
      .word    (ir_q),
      .flags   (ir_flags_s),
      .illegal (ir_illegal_s)
   );

   opcode_decode #(.NOP_WORD(NOP_WORD)) u_dec_mem (
      .word    (mem_rdata),
      .flags   (mem_flags_s),
      .illegal (mem_illegal_s)
   );

   // A word with any class flag is never counted illegal, even on a decoder upset.
   assign cap_illegal_s = mem_illegal_s & ~(|mem_flags_s);

   // Next-state for IR, trap pulse, sticky status and counters; clear beats counting.
   always_comb begin
      ir_d       = ir_q;
      trap_d     = 1'b0;
      seen_d     = seen_q;
      inst_cnt_d = inst_cnt_q;
      ill_cnt_d  = ill_cnt_q;
      if (ir_write) begin
         ir_d   = mem_rdata;
         trap_d = cap_illegal_s;
      end else begin
         ir_d   = ir_q;
         trap_d = 1'b0;
      end
      if (clr_cnt) begin
         seen_d     = 1'b0;
         inst_cnt_d = 32'h0000_0000;
         ill_cnt_d  = '0;
      end else if (ir_write) begin
         inst_cnt_d = inst_cnt_q + 32'h0000_0001;
         if (cap_illegal_s) begin
            seen_d = 1'b1;
            if (ill_cnt_q != '1) begin
               ill_cnt_d = ill_cnt_q + ILL_ONE;
            end else begin
               ill_cnt_d = ill_cnt_q;
            end
         end else begin
            seen_d = seen_q;
         end
      end else begin
         inst_cnt_d = inst_cnt_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ir_q       <= 32'h0000_0000;
         trap_q     <= 1'b0;
         seen_q     <= 1'b0;
         inst_cnt_q <= 32'h0000_0000;
         ill_cnt_q  <= '0;
      end else begin
         ir_q       <= ir_d;
         trap_q     <= trap_d;
         seen_q     <= seen_d;
         inst_cnt_q <= inst_cnt_d;
         ill_cnt_q  <= ill_cnt_d;
      end
   end

   assign ir           = ir_q;
   assign rs_idx       = ir_q[25:21];
   assign rt_idx       = ir_q[20:16];
   assign rd_idx       = ir_q[15:11];
   assign funct        = ir_q[5:0];
   assign imm_sext     = {{16{ir_q[15]}}, ir_q[15:0]};
   assign jtarget      = ir_q[25:0];
   assign RT           = ir_flags_s.rt;
   assign addi         = ir_flags_s.addi;
   assign andi         = ir_flags_s.andi;
   assign lw           = ir_flags_s.lw;
   assign sw           = ir_flags_s.sw;
   assign j            = ir_flags_s.j;
   assign jal          = ir_flags_s.jal;
   assign jr           = ir_flags_s.jr;
   assign beq          = ir_flags_s.beq;
   assign bne          = ir_flags_s.bne;
   assign illegal      = ir_illegal_s;
   assign trap         = trap_q;
   assign illegal_seen = seen_q;
   assign inst_cnt     = inst_cnt_q;
   assign illegal_cnt  = ill_cnt_q;

endmodule

// File: tb/tb_inst_decode_reg.sv
// Directed self-checking bench for inst_decode_reg; illegal counter is
// narrowed to 4 bits so saturation is reached in a handful of captures.
module tb_inst_decode_reg;

   localparam int ILL_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [31:0]       mem_rdata = 32'h0;
   logic              ir_write = 1'b0;
   logic              clr_cnt = 1'b0;
   logic [31:0]       ir, imm_sext, inst_cnt;
   logic [4:0]        rs_idx, rt_idx, rd_idx;
   logic [5:0]        funct;
   logic [25:0]       jtarget;
   logic              RT, addi, andi, lw, sw, j, jal, jr, beq, bne;
   logic              illegal, trap, illegal_seen;
   logic [ILL_W-1:0]  illegal_cnt;
   logic [9:0]        flags;

   int nvec = 0;
   int nerr = 0;
   logic [31:0]      exp_inst = 32'h0;
   logic [ILL_W-1:0] exp_ill  = '0;

   assign flags = {RT, addi, andi, lw, sw, j, jal, jr, beq, bne};

   inst_decode_reg #(.NOP_WORD(32'h0000_0000), .ILL_CNT_W(ILL_W)) dut (
      .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .ir_write(ir_write), .clr_cnt(clr_cnt),
      .ir(ir), .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx), .funct(funct),
      .imm_sext(imm_sext), .jtarget(jtarget),
      .RT(RT), .addi(addi), .andi(andi), .lw(lw), .sw(sw), .j(j), .jal(jal), .jr(jr),
      .beq(beq), .bne(bne), .illegal(illegal), .trap(trap), .illegal_seen(illegal_seen),
      .inst_cnt(inst_cnt), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   // Drive one capture at a negedge; returns at the next negedge with ir_write dropped
   // and mem_rdata scrambled to an illegal pattern so decode must come from IR.
   task automatic capture(input logic [31:0] w);
      mem_rdata = w;
      ir_write  = 1'b1;
      @(negedge clk);
      ir_write  = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      ir_write = 1'b1; clr_cnt = 1'b0; mem_rdata = 32'h8C22_0004;
      repeat (2) @(negedge clk);
      ir_write = 1'b0; rst = 1'b1;
      repeat (3) @(negedge clk);
      nvec++; if (ir !== 32'h0) begin nerr++; $display("FAIL reset_ir got %h exp %h", ir, 32'h0); end
      nvec++; if (flags !== 10'b0 || illegal !== 1'b0) begin nerr++; $display("FAIL reset_flags got %b/%b exp 0/0", flags, illegal); end
      nvec++; if (imm_sext !== 32'h0 || jtarget !== 26'h0) begin nerr++; $display("FAIL reset_imm got %h/%h exp 0/0", imm_sext, jtarget); end
      nvec++; if (trap !== 1'b0 || illegal_seen !== 1'b0) begin nerr++; $display("FAIL reset_status got %b/%b exp 0/0", trap, illegal_seen); end
      nvec++; if (inst_cnt !== 32'h0 || illegal_cnt !== '0) begin nerr++; $display("FAIL reset_cnt got %h/%h exp 0/0", inst_cnt, illegal_cnt); end
   endtask

   task automatic test_lw();
      capture(32'h8C22_0004);
      exp_inst = exp_inst + 32'd1;
      nvec++; if (flags !== 10'b0001000000) begin nerr++; $display("FAIL lw_flags got %b exp %b", flags, 10'b0001000000); end
      nvec++; if (rs_idx !== 5'd1 || rt_idx !== 5'd2 || rd_idx !== 5'd0) begin nerr++; $display("FAIL lw_idx got %0d/%0d/%0d exp 1/2/0", rs_idx, rt_idx, rd_idx); end
      nvec++; if (imm_sext !== 32'h0000_0004 || funct !== 6'd4) begin nerr++; $display("FAIL lw_imm got %h/%h exp 4/4", imm_sext, funct); end
      nvec++; if (jtarget !== 26'h022_0004) begin nerr++; $display("FAIL lw_jtarget got %h exp %h", jtarget, 26'h022_0004); end
      nvec++; if (inst_cnt !== exp_inst || trap !== 1'b0) begin nerr++; $display("FAIL lw_cnt got %0d/%b exp %0d/0", inst_cnt, trap, exp_inst); end
   endtask

   task automatic test_back_to_back();
      mem_rdata = 32'h2001_FFFF; ir_write = 1'b1;
      @(negedge clk);
      exp_inst = exp_inst + 32'd1;
      nvec++; if (addi !== 1'b1 || flags !== 10'b0100000000) begin nerr++; $display("FAIL addi_flags got %b exp %b", flags, 10'b0100000000); end
      nvec++; if (imm_sext !== 32'hFFFF_FFFF || rt_idx !== 5'd1) begin nerr++; $display("FAIL addi_sext got %h/%0d exp ffffffff/1", imm_sext, rt_idx); end
      mem_rdata = 32'h03E0_0008;
      @(negedge clk);
      ir_write = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      exp_inst = exp_inst + 32'd1;
      nvec++; if (jr !== 1'b1 || RT !== 1'b0 || flags !== 10'b0000000100) begin nerr++; $display("FAIL jr_flags got %b exp %b", flags, 10'b0000000100); end
      nvec++; if (rs_idx !== 5'd31) begin nerr++; $display("FAIL jr_rs got %0d exp 31", rs_idx); end
      nvec++; if (inst_cnt !== exp_inst) begin nerr++; $display("FAIL b2b_cnt got %0d exp %0d", inst_cnt, exp_inst); end
   endtask

   typedef struct {
      logic [31:0] w;
      logic [9:0]  f;
      logic        ill;
   } vec_t;

   task automatic test_decode_table();
      vec_t tbl[11];
      tbl[0]  = '{32'h0022_1820, 10'b1000000000, 1'b0};  // add
      tbl[1]  = '{32'h0022_182A, 10'b1000000000, 1'b0};  // slt
      tbl[2]  = '{32'h3021_00FF, 10'b0010000000, 1'b0};  // andi
      tbl[3]  = '{32'hAC22_0004, 10'b0000100000, 1'b0};  // sw
      tbl[4]  = '{32'h0800_0010, 10'b0000010000, 1'b0};  // j
      tbl[5]  = '{32'h0C00_0010, 10'b0000001000, 1'b0};  // jal
      tbl[6]  = '{32'h1022_0003, 10'b0000000010, 1'b0};  // beq
      tbl[7]  = '{32'h1422_FFFD, 10'b0000000001, 1'b0};  // bne
      tbl[8]  = '{32'h0000_0000, 10'b0000000000, 1'b0};  // nop
      tbl[9]  = '{32'h0000_0001, 10'b0000000000, 1'b1};  // bad funct
      tbl[10] = '{32'h0022_1822, 10'b1000000000, 1'b0};  // sub
      for (int i = 0; i < 11; i++) begin
         capture(tbl[i].w);
         exp_inst = exp_inst + 32'd1;
         if (tbl[i].ill) exp_ill = exp_ill + 1'b1;
         nvec++; if (ir !== tbl[i].w) begin nerr++; $display("FAIL tbl%0d_ir got %h exp %h", i, ir, tbl[i].w); end
         nvec++; if (flags !== tbl[i].f || illegal !== tbl[i].ill) begin nerr++; $display("FAIL tbl%0d_dec got %b/%b exp %b/%b", i, flags, illegal, tbl[i].f, tbl[i].ill); end
         nvec++; if (trap !== tbl[i].ill) begin nerr++; $display("FAIL tbl%0d_trap got %b exp %b", i, trap, tbl[i].ill); end
      end
      nvec++; if (rd_idx !== 5'd3 || funct !== 6'b100010) begin nerr++; $display("FAIL tbl_rd got %0d/%b exp 3/100010", rd_idx, funct); end
      nvec++; if (inst_cnt !== exp_inst || illegal_cnt !== exp_ill || illegal_seen !== 1'b1) begin nerr++; $display("FAIL tbl_cnt got %0d/%0d/%b exp %0d/%0d/1", inst_cnt, illegal_cnt, illegal_seen, exp_inst, exp_ill); end
   endtask

   task automatic test_illegal();
      capture(32'hFC00_0000);
      exp_inst = exp_inst + 32'd1;
      exp_ill  = exp_ill + 1'b1;
      nvec++; if (illegal !== 1'b1 || flags !== 10'b0) begin nerr++; $display("FAIL ill_dec got %b/%b exp 1/0", illegal, flags); end
      nvec++; if (trap !== 1'b1) begin nerr++; $display("FAIL ill_trap got %b exp 1", trap); end
      nvec++; if (illegal_seen !== 1'b1 || illegal_cnt !== exp_ill) begin nerr++; $display("FAIL ill_status got %b/%0d exp 1/%0d", illegal_seen, illegal_cnt, exp_ill); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         nvec++; if (trap !== 1'b0 || illegal !== 1'b1) begin nerr++; $display("FAIL ill_hold%0d got trap %b ill %b exp 0/1", i, trap, illegal); end
      end
      nvec++; if (inst_cnt !== exp_inst || ir !== 32'hFC00_0000) begin nerr++; $display("FAIL ill_holdcnt got %0d/%h exp %0d/fc000000", inst_cnt, ir, exp_inst); end
   endtask

   task automatic test_clr_with_capture();
      clr_cnt = 1'b1;
      capture(32'hFC00_0000);
      clr_cnt = 1'b0;
      exp_inst = 32'h0;
      exp_ill  = '0;
      nvec++; if (ir !== 32'hFC00_0000 || trap !== 1'b1) begin nerr++; $display("FAIL clr_ir_trap got %h/%b exp fc000000/1", ir, trap); end
      nvec++; if (inst_cnt !== 32'h0 || illegal_cnt !== '0 || illegal_seen !== 1'b0) begin nerr++; $display("FAIL clr_cnt got %0d/%0d/%b exp 0/0/0", inst_cnt, illegal_cnt, illegal_seen); end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 16; i++) begin
         capture(32'hFC00_0000 | 32'(i));
         exp_inst = exp_inst + 32'd1;
         if (exp_ill != '1) exp_ill = exp_ill + 1'b1;
      end
      nvec++; if (illegal_cnt !== 4'hF || illegal_cnt !== exp_ill) begin nerr++; $display("FAIL sat_cnt got %h exp %h", illegal_cnt, 4'hF); end
      nvec++; if (inst_cnt !== 32'd16) begin nerr++; $display("FAIL sat_inst got %0d exp 16", inst_cnt); end
      capture(32'h8C22_0004);
      nvec++; if (inst_cnt !== 32'd17 || illegal_cnt !== 4'hF || trap !== 1'b0) begin nerr++; $display("FAIL sat_legal got %0d/%h/%b exp 17/f/0", inst_cnt, illegal_cnt, trap); end
   endtask

   task automatic test_hold();
      mem_rdata = 32'h2001_FFFF;
      repeat (2) @(negedge clk);
      nvec++; if (ir !== 32'h8C22_0004 || lw !== 1'b1 || inst_cnt !== 32'd17) begin nerr++; $display("FAIL hold got %h/%b/%0d exp 8c220004/1/17", ir, lw, inst_cnt); end
   endtask

   task automatic test_reset_mid();
      rst = 1'b0;
      ir_write = 1'b1; clr_cnt = 1'b0; mem_rdata = 32'hFC00_0000;
      @(negedge clk);
      ir_write = 1'b0; rst = 1'b1;
      nvec++; if (ir !== 32'h0 || flags !== 10'b0 || illegal !== 1'b0) begin nerr++; $display("FAIL rstmid_ir got %h/%b/%b exp 0/0/0", ir, flags, illegal); end
      nvec++; if (trap !== 1'b0 || illegal_seen !== 1'b0) begin nerr++; $display("FAIL rstmid_status got %b/%b exp 0/0", trap, illegal_seen); end
      nvec++; if (inst_cnt !== 32'h0 || illegal_cnt !== '0) begin nerr++; $display("FAIL rstmid_cnt got %0d/%0d exp 0/0", inst_cnt, illegal_cnt); end
      capture(32'h0800_0010);
      nvec++; if (j !== 1'b1 || inst_cnt !== 32'd1 || jtarget !== 26'h10) begin nerr++; $display("FAIL post_rst got %b/%0d/%h exp 1/1/10", j, inst_cnt, jtarget); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_lw();
      test_back_to_back();
      test_decode_table();
      test_illegal();
      test_clr_with_capture();
      test_saturate();
      test_hold();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
